pcie_ss_tx_local_commit: RTL and testbench

- Sits on the merged PCIe SS TX TLP stream after A/B arbitration, in front of the ASE PCIe SS emulator.
- Passes every TX packet through unchanged.
- For each memory-write request that enters the TX path, it synthesizes a local write-commit message. These messages go out on a separate RX-side AXI-S stream, which the host-channel logic later merges into RX-A or RX-B.

---
 rtl/pcie_ss_tx_local_commit_if.sv | 33 +++
 rtl/pcie_ss_tx_local_commit.sv | 90 +++++++++
 tb/tb_pcie_ss_tx_local_commit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_ss_tx_local_commit_if.sv
// AXI-Stream bundle used for the PCIe SS TX path and the synthesized
// commit stream. master drives the payload and valid; slave drives ready.
interface pcie_ss_tx_local_commit_if #(
  parameter int TDATA_W = 512,
  parameter int TUSER_W = 10
);
  localparam int TKEEP_W = TDATA_W / 8;

  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic [TDATA_W-1:0] tdata;
  logic [TKEEP_W-1:0] tkeep;
  logic [TUSER_W-1:0] tuser_vendor;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    output tkeep,
    output tuser_vendor,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    input  tkeep,
    input  tuser_vendor,
    output tready
  );
endinterface

// File: rtl/pcie_ss_tx_local_commit.sv
// Passes the merged PCIe SS TX stream through untouched and, for every
// memory-write header accepted on the source side, queues a single-beat
// local write-commit (CplNoData-style header) on a separate stream.
module pcie_ss_tx_local_commit #(
  parameter int TDATA_W      = 512,
  parameter int TKEEP_W      = TDATA_W / 8,
  parameter int TUSER_W      = 10,
  parameter int COMMIT_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pcie_ss_tx_local_commit_if.slave   sink,
  pcie_ss_tx_local_commit_if.master  source,
  pcie_ss_tx_local_commit_if.master  commit
);

  localparam int AW      = $clog2(COMMIT_DEPTH);
  localparam int HDR_W   = 256;
  localparam int ENTRY_W = HDR_W + TUSER_W;
  localparam logic [7:0] FMT_CPL = 8'h0A;

  logic               sop;
  logic               is_wr;
  logic               block;
  logic               src_hs;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [COMMIT_DEPTH];
  logic [ENTRY_W-1:0] head;

  // Header decode only matters on SOP beats; MWr32/MWr64 share fmt[6]=1, type=0.
  assign is_wr = sink.tdata[30] && (sink.tdata[28:24] == 5'd0);

  // Only a write header stalls, and only against the registered full flag.
  assign block = sop && is_wr && fifo_full;

  assign source.tvalid       = sink.tvalid && !block;
  assign source.tdata        = sink.tdata;
  assign source.tkeep        = sink.tkeep;
  assign source.tlast        = sink.tlast;
  assign source.tuser_vendor = sink.tuser_vendor;
  assign sink.tready         = source.tready && !block;

  assign src_hs = source.tvalid && source.tready;
  assign push   = src_hs && sop && is_wr;
  assign pop    = commit.tvalid && commit.tready;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Next accepted beat is a header whenever the previous accepted beat was EOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop <= 1'b1;
    end else if (src_hs) begin
      sop <= sink.tlast;
    end
  end

  // Commit FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Store the header already rewritten as a completion, plus the request tuser.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {sink.tuser_vendor, sink.tdata[HDR_W-1:32], FMT_CPL, sink.tdata[23:0]};
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

  assign commit.tvalid       = !fifo_empty;
  assign commit.tdata        = {{(TDATA_W-HDR_W){1'b0}}, head[HDR_W-1:0]};
  assign commit.tkeep        = {{(TKEEP_W-32){1'b0}}, {32{1'b1}}};
  assign commit.tlast        = 1'b1;
  assign commit.tuser_vendor = head[ENTRY_W-1:HDR_W];

endmodule

// File: tb/tb_pcie_ss_tx_local_commit.sv
// Scoreboard bench: drivers push expected beats into queues, independent
// monitors pop and compare whenever a handshake is presented.
module tb_pcie_ss_tx_local_commit;
  localparam int TDATA_W = 512;
  localparam int TKEEP_W = 64;
  localparam int TUSER_W = 10;

  typedef struct {
    logic [TDATA_W-1:0] data;
    logic [TKEEP_W-1:0] keep;
    logic               last;
    logic [TUSER_W-1:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_ss_tx_local_commit_if #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W)) snk_if ();
  pcie_ss_tx_local_commit_if #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W)) src_if ();
  pcie_ss_tx_local_commit_if #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W)) cmt_if ();

  pcie_ss_tx_local_commit #(
    .TDATA_W(TDATA_W), .TKEEP_W(TKEEP_W), .TUSER_W(TUSER_W), .COMMIT_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sink(snk_if), .source(src_if), .commit(cmt_if)
  );

  beat_t src_q[$];
  beat_t cmt_q[$];
  int checks = 0;
  int errors = 0;
  int commit_seen = 0;

  task automatic check(input string name, input logic [TDATA_W-1:0] act, input logic [TDATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [TDATA_W-1:0] mk_hdr(input logic [7:0] fmt, input logic [7:0] tag, input logic [9:0] len);
    logic [TDATA_W-1:0] d;
    d = '0;
    for (int i = 8; i < 16; i++) d[i*32 +: 32] = 32'hC0DE_0000 | (32'(i) << 8) | {24'd0, tag};
    d[255:64] = {6{32'h5A5A_0000 | {24'd0, tag}}};
    d[63:48]  = 16'h0102;
    d[47:40]  = tag;
    d[39:32]  = 8'h0F;
    d[31:24]  = fmt;
    d[23:10]  = 14'h1A5;
    d[9:0]    = len;
    return d;
  endfunction

  // Payload beats carry 8'h40 in bits [31:24] so a mis-tracked SOP would look like a write.
  function automatic logic [TDATA_W-1:0] mk_pay(input logic [7:0] tag, input logic [7:0] idx);
    logic [TDATA_W-1:0] d;
    d = {16{8'h40, tag, idx, 8'hEE}};
    return d;
  endfunction

  function automatic beat_t exp_commit(input logic [TDATA_W-1:0] hdr, input logic [TUSER_W-1:0] user);
    beat_t b;
    b.data = '0;
    b.data[255:0] = hdr[255:0];
    b.data[31:24] = 8'h0A;
    b.keep = 64'h0000_0000_FFFF_FFFF;
    b.last = 1'b1;
    b.user = user;
    return b;
  endfunction

  // Source monitor: every accepted TX beat must match the next driven beat.
  always @(negedge clk) begin
    if (rst_n && src_if.tvalid && src_if.tready) begin
      if (src_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL src_unexpected actual=%0h required=none", src_if.tdata[63:0]);
      end else begin
        beat_t e;
        e = src_q.pop_front();
        check("src_data", src_if.tdata, e.data);
        check("src_keep", TDATA_W'(src_if.tkeep), TDATA_W'(e.keep));
        check("src_last", TDATA_W'(src_if.tlast), TDATA_W'(e.last));
        check("src_user", TDATA_W'(src_if.tuser_vendor), TDATA_W'(e.user));
      end
    end
  end

  // Commit monitor: every popped commit must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && cmt_if.tvalid && cmt_if.tready) begin
      commit_seen++;
      if (cmt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmt_unexpected actual=%0h required=none", cmt_if.tdata[63:0]);
      end else begin
        beat_t e;
        e = cmt_q.pop_front();
        check("cmt_data", cmt_if.tdata, e.data);
        check("cmt_keep", TDATA_W'(cmt_if.tkeep), TDATA_W'(e.keep));
        check("cmt_last", TDATA_W'(cmt_if.tlast), TDATA_W'(e.last));
        check("cmt_user", TDATA_W'(cmt_if.tuser_vendor), TDATA_W'(e.user));
      end
    end
  end

  // Drives one beat from posedge+1 until accepted; wr_hdr marks a write header.
  task automatic send(input logic [TDATA_W-1:0] d, input logic last, input logic [TUSER_W-1:0] user,
                      input logic wr_hdr, output int stalls);
    beat_t b;
    logic acc;
    b.data = d;
    b.keep = last ? 64'h0000_0000_0000_FFFF : '1;
    b.last = last;
    b.user = user;
    snk_if.tvalid = 1'b1;
    snk_if.tdata = d;
    snk_if.tkeep = b.keep;
    snk_if.tlast = last;
    snk_if.tuser_vendor = user;
    src_q.push_back(b);
    stalls = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (snk_if.tready) begin
        acc = 1'b1;
        if (wr_hdr) cmt_q.push_back(exp_commit(d, user));
      end else begin
        stalls++;
        if (stalls > 300) begin
          $display("FAIL send_timeout actual=stalled required=accepted");
          $fatal(1, "send timeout");
        end
      end
      @(posedge clk);
      #1;
    end
    snk_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cmt_q.size() != 0 || src_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_bound", TDATA_W'(n < 500), TDATA_W'(1));
  endtask

  initial begin
    int st;
    int c0;
    snk_if.tvalid = 1'b0;
    snk_if.tdata = '0;
    snk_if.tkeep = '0;
    snk_if.tlast = 1'b0;
    snk_if.tuser_vendor = '0;
    src_if.tready = 1'b1;
    cmt_if.tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmt_valid", TDATA_W'(cmt_if.tvalid), TDATA_W'(0));
    check("rst_sink_ready", TDATA_W'(snk_if.tready), TDATA_W'(1));
    src_if.tready = 1'b0;
    snk_if.tvalid = 1'b1;
    #1;
    check("rst_src_follow", TDATA_W'(src_if.tvalid), TDATA_W'(1));
    snk_if.tvalid = 1'b0;
    src_if.tready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single-beat MWr64
    send(mk_hdr(8'h60, 8'h15, 10'd1), 1'b1, 10'h201, 1'b1, st);
    check("t1_cmt_valid", TDATA_W'(cmt_if.tvalid), TDATA_W'(1));
    check("t1_cmt_fmt", TDATA_W'(cmt_if.tdata[31:24]), TDATA_W'(8'h0A));
    check("t1_cmt_tag", TDATA_W'(cmt_if.tdata[47:40]), TDATA_W'(8'h15));
    check("t1_cmt_keep", TDATA_W'(cmt_if.tkeep), TDATA_W'(64'h0000_0000_FFFF_FFFF));
    check("t1_cmt_last", TDATA_W'(cmt_if.tlast), TDATA_W'(1));
    drain();

    // 2: 4-beat MWr32 then MRd
    c0 = commit_seen;
    send(mk_hdr(8'h40, 8'h21, 10'd4), 1'b0, 10'h011, 1'b1, st);
    check("t2_cmt_before_eop", TDATA_W'(cmt_if.tvalid), TDATA_W'(1));
    send(mk_pay(8'h21, 8'd1), 1'b0, 10'h011, 1'b0, st);
    send(mk_pay(8'h21, 8'd2), 1'b0, 10'h011, 1'b0, st);
    send(mk_pay(8'h21, 8'd3), 1'b1, 10'h011, 1'b0, st);
    check("t2_sop_after_eop", TDATA_W'(dut.sop), TDATA_W'(1));
    send(mk_hdr(8'h20, 8'h22, 10'd2), 1'b1, 10'h012, 1'b0, st);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("t2_commit_count", TDATA_W'(commit_seen - c0), TDATA_W'(1));

    // 3: fill FIFO, 9th write blocked, non-write passes, then drain in order
    cmt_if.tready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(mk_hdr(8'h60, 8'h30 + 8'(i), 10'd1), 1'b1, 10'(i), 1'b1, st);
    snk_if.tvalid = 1'b1;
    snk_if.tdata = mk_hdr(8'h60, 8'h38, 10'd1);
    snk_if.tlast = 1'b1;
    @(negedge clk);
    check("t3_full_sink_ready", TDATA_W'(snk_if.tready), TDATA_W'(0));
    check("t3_full_src_valid", TDATA_W'(src_if.tvalid), TDATA_W'(0));
    @(posedge clk);
    #1;
    send(mk_hdr(8'h20, 8'h50, 10'd1), 1'b1, 10'h050, 1'b0, st);
    check("t3_rd_not_blocked", TDATA_W'(st), TDATA_W'(0));
    fork
      send(mk_hdr(8'h60, 8'h38, 10'd1), 1'b1, 10'd8, 1'b1, st);
      begin
        repeat (3) @(posedge clk);
        #1;
        cmt_if.tready = 1'b1;
      end
    join
    check("t3_ninth_stalled", TDATA_W'(st >= 3), TDATA_W'(1));
    drain();

    // 4: full FIFO, commit_tready=1, write stalls exactly one cycle
    cmt_if.tready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(mk_hdr(8'h40, 8'h60 + 8'(i), 10'd1), 1'b1, 10'h100 + 10'(i), 1'b1, st);
    cmt_if.tready = 1'b1;
    c0 = commit_seen;
    send(mk_hdr(8'h60, 8'h68, 10'd1), 1'b1, 10'h108, 1'b1, st);
    check("t4_one_stall", TDATA_W'(st), TDATA_W'(1));
    drain();
    check("t4_commit_count", TDATA_W'(commit_seen - c0), TDATA_W'(9));

    // 5: source_tready toggling during a 3-beat write
    c0 = commit_seen;
    fork
      begin
        send(mk_hdr(8'h60, 8'h70, 10'd3), 1'b0, 10'h070, 1'b1, st);
        send(mk_pay(8'h70, 8'd1), 1'b0, 10'h070, 1'b0, st);
        send(mk_pay(8'h70, 8'd2), 1'b1, 10'h070, 1'b0, st);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          #1;
          src_if.tready = ~src_if.tready;
        end
        src_if.tready = 1'b1;
      end
    join
    drain();
    check("t5_commit_count", TDATA_W'(commit_seen - c0), TDATA_W'(1));

    // 6: async reset mid-packet with 3 commits queued
    cmt_if.tready = 1'b0;
    send(mk_hdr(8'h60, 8'h80, 10'd1), 1'b1, 10'h080, 1'b1, st);
    send(mk_hdr(8'h60, 8'h81, 10'd1), 1'b1, 10'h081, 1'b1, st);
    send(mk_hdr(8'h40, 8'h82, 10'd2), 1'b0, 10'h082, 1'b1, st);
    check("t6_cmt_queued", TDATA_W'(cmt_if.tvalid), TDATA_W'(1));
    src_if.tready = 1'b0;
    snk_if.tvalid = 1'b1;
    snk_if.tdata = mk_pay(8'h82, 8'd1);
    snk_if.tlast = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cmt_drop", TDATA_W'(cmt_if.tvalid), TDATA_W'(0));
    check("t6_rst_src_follow", TDATA_W'(src_if.tvalid), TDATA_W'(1));
    cmt_q.delete();
    snk_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_if.tready = 1'b1;
    cmt_if.tready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_sop_after_rst", TDATA_W'(dut.sop), TDATA_W'(1));
    c0 = commit_seen;
    send(mk_hdr(8'h60, 8'h91, 10'd1), 1'b1, 10'h091, 1'b1, st);
    drain();
    check("t6_commit_count", TDATA_W'(commit_seen - c0), TDATA_W'(1));

    check("end_src_q_empty", TDATA_W'(src_q.size()), TDATA_W'(0));
    check("end_cmt_q_empty", TDATA_W'(cmt_q.size()), TDATA_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
